vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Shares one VRAM memory port between two request/ready masters: port A (CPU write buffer) and port B (video scanline fetch). Port B has fixed priority so line fetches meet hblank deadlines. A starvation guard gives port A one grant after a bounded run of port B grants. The block sits between the video controller's masters and the single VRAM port of the memory controller.

## Interface
- MAX_B_BURST, 16, consecutive B grants allowed while A is pending before A must be granted; legal range ≥ 1.
- i_clock  in  1  system clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_pa_request / i_pb_request  in  1  port request; held high until the port's ready pulse.
- i_pa_rw / i_pb_rw  in  1  1 = write, 0 = read.
- i_pa_address / i_pb_address  in  32  byte address.
- i_pa_wdata / i_pb_wdata  in  32  write data.
- o_pa_rdata / o_pb_rdata  out  32  read data; valid in the ready cycle.
- o_pa_ready / o_pb_ready  out  1  one-cycle completion pulse.
- o_vram_request  out  1  memory request; held until i_vram_ready.
- o_vram_rw  out  1  forwarded rw.
- o_vram_address  out  32  forwarded address.
- o_vram_wdata  out  32  forwarded write data.
- i_vram_rdata  in  32  memory read data.
- i_vram_ready  in  1  memory completion; sampled only while o_vram_request = 1.
- o_owner  out  1  0 = A, 1 = B; last or current grant.
- o_busy  out  1  1 from grant until the port's ready cycle, inclusive.

## Operation
- The FSM has three states: IDLE, GRANT, DONE.
- **IDLE.** Sample both requests.
  - Neither request: stay in IDLE.
  - Only A: grant A.
  - Only B: grant B.
  - Both, and burst counter < MAX_B_BURST: grant B.
  - Both, and burst counter = MAX_B_BURST: grant A.
  - On grant: latch rw, address and wdata into the o_vram_* registers; set o_vram_request = 1; set o_owner; go to GRANT.
- **GRANT.** Hold all o_vram_* outputs stable.
  - On i_vram_ready: clear o_vram_request; copy i_vram_rdata into the owner's o_pX_rdata; set the owner's o_pX_ready = 1; go to DONE.
- **DONE.** Clear o_pX_ready; go to IDLE.
  - Requests are not sampled in DONE. A master sees ready in this cycle and may present a new request at the following edge.
- **Burst counter.** Saturating, width $clog2(MAX_B_BURST+1).
  - B granted while A is requesting: increment.
  - B granted while A is idle: reset to 0.
  - A granted: reset to 0.
- The non-owner port's ready stays 0 and its rdata holds its last value.

## Timing
- **Reset values.** Every output is 0: o_vram_*, o_pa_*, o_pb_*, o_owner, o_busy. The FSM is in IDLE and the burst counter is 0.
- **Reset mid-transaction.** Drop o_vram_request immediately (asynchronous). No ready pulse is issued for the abandoned transaction.
- **Request to memory.** A request that is high in IDLE cycle t produces o_vram_request = 1 from cycle t+1.
- **Memory to port.** i_vram_ready in cycle g produces o_pX_ready = 1 in cycle g+1.
- **Throughput.** With single-cycle memory (ready in the first grant cycle), one transaction completes every 3 cycles and the port latency is 2 cycles.
- **Request dropped while granted.** This is a protocol violation. The transaction still completes and ready still pulses.
- **i_vram_ready outside GRANT.** Ignored.
- **Simultaneous request changes.** Any change on the non-owner port during GRANT/DONE has no effect until the next IDLE.
- **o_busy.** Registered; equals (state == GRANT) || (state == DONE).

## Test plan
- **Single read on A.** Stimulus: A reads 0x100; memory returns 0xDEADBEEF with ready in the first grant cycle. Required: o_vram_address = 0x100 one cycle after the request; o_pa_rdata = 0xDEADBEEF with o_pa_ready for exactly 1 cycle; o_pb_ready stays 0.
- **Simultaneous first request.** Stimulus: A writes 0x10 = 0x55, B reads 0x2000, both raised in the same cycle. Required: B is served first, then A; memory sees rw=0 @0x2000, then rw=1 @0x10 with wdata 0x55.
- **Starvation guard.** Stimulus: B holds its request continuously, with address stepping by 4 after each ready; A holds one write; MAX_B_BURST = 4. Required: exactly 4 B grants, then 1 A grant, then B resumes; counter is 0 after the A grant.
- **Memory wait states.** Stimulus: i_vram_ready delayed 5 cycles. Required: o_vram_* stable across all 5 wait cycles; ready pulses once, 1 cycle after i_vram_ready.
- **Reset mid-transaction.** Stimulus: i_reset asserted while in GRANT. Required: o_vram_request falls without waiting for a clock edge; no o_pX_ready pulse; the next request after reset is granted normally.
- **Stray memory ready.** Stimulus: i_vram_ready pulsed while in IDLE with no requests. Required: no state change and no ready outputs.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Arbitrates one VRAM port between a CPU write-buffer master (A) and a fixed-priority
// scanline fetch master (B); a burst counter forces an A grant after a bounded B run.
module vram_port_arbiter #(
  parameter int unsigned MAX_B_BURST = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_ready,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_ready,
  output logic        o_vram_request,
  output logic        o_vram_rw,
  output logic [31:0] o_vram_address,
  output logic [31:0] o_vram_wdata,
  input  logic [31:0] i_vram_rdata,
  input  logic        i_vram_ready,
  output logic        o_owner,
  output logic        o_busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(MAX_B_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_B_BURST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_burst;
  logic          r_owner;
  logic          r_busy;
  logic          r_vram_request;
  logic          r_vram_rw;
  logic [DW-1:0] r_vram_address;
  logic [DW-1:0] r_vram_wdata;
  logic [DW-1:0] r_pa_rdata;
  logic [DW-1:0] r_pb_rdata;
  logic          r_pa_ready;
  logic          r_pb_ready;

  logic          w_any_request;
  logic          w_grant_b;
  logic [CW-1:0] w_burst_next;

  // B wins unless A is also waiting and B has already used up its burst allowance
  assign w_any_request = i_pa_request | i_pb_request;
  assign w_grant_b     = i_pb_request & (~i_pa_request | (r_burst != BURST_MAX));

  // A B grant with A waiting implies r_burst < BURST_MAX, so the increment cannot wrap
  assign w_burst_next  = (w_grant_b & i_pa_request) ? r_burst + CW'(1) : '0;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_burst        <= '0;
      r_owner        <= 1'b0;
      r_busy         <= 1'b0;
      r_vram_request <= 1'b0;
      r_vram_rw      <= 1'b0;
      r_vram_address <= '0;
      r_vram_wdata   <= '0;
      r_pa_rdata     <= '0;
      r_pb_rdata     <= '0;
      r_pa_ready     <= 1'b0;
      r_pb_ready     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_request) begin
            r_owner        <= w_grant_b;
            r_busy         <= 1'b1;
            r_vram_request <= 1'b1;
            r_vram_rw      <= w_grant_b ? i_pb_rw      : i_pa_rw;
            r_vram_address <= w_grant_b ? i_pb_address : i_pa_address;
            r_vram_wdata   <= w_grant_b ? i_pb_wdata   : i_pa_wdata;
            r_burst        <= w_burst_next;
            r_state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (i_vram_ready) begin
            r_vram_request <= 1'b0;
            if (r_owner) begin
              r_pb_rdata <= i_vram_rdata;
              r_pb_ready <= 1'b1;
            end else begin
              r_pa_rdata <= i_vram_rdata;
              r_pa_ready <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_pa_ready <= 1'b0;
          r_pb_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pa_rdata     = r_pa_rdata;
  assign o_pa_ready     = r_pa_ready;
  assign o_pb_rdata     = r_pb_rdata;
  assign o_pb_ready     = r_pb_ready;
  assign o_vram_request = r_vram_request;
  assign o_vram_rw      = r_vram_rw;
  assign o_vram_address = r_vram_address;
  assign o_vram_wdata   = r_vram_wdata;
  assign o_owner        = r_owner;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed vectors, multi-cycle corner
// sequences, then random masters/memory against a transaction-level reference model.
module tb_vram_port_arbiter;

  localparam int unsigned MAXB = 4;

  logic        clk;
  logic        rst;
  logic        pa_req, pa_rw, pb_req, pb_rw;
  logic [31:0] pa_addr, pa_wdata, pb_addr, pb_wdata;
  logic [31:0] o_pa_rdata, o_pb_rdata;
  logic        o_pa_ready, o_pb_ready;
  logic        o_vram_request, o_vram_rw;
  logic [31:0] o_vram_address, o_vram_wdata;
  logic [31:0] vram_rdata;
  logic        vram_ready;
  logic        o_owner, o_busy;

  int n_checks;
  int n_errors;

  logic [31:0] exp_pa_rdata, exp_pb_rdata;

  vram_port_arbiter #(.MAX_B_BURST(MAXB)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_pa_request   (pa_req),
    .i_pa_rw        (pa_rw),
    .i_pa_address   (pa_addr),
    .i_pa_wdata     (pa_wdata),
    .o_pa_rdata     (o_pa_rdata),
    .o_pa_ready     (o_pa_ready),
    .i_pb_request   (pb_req),
    .i_pb_rw        (pb_rw),
    .i_pb_address   (pb_addr),
    .i_pb_wdata     (pb_wdata),
    .o_pb_rdata     (o_pb_rdata),
    .o_pb_ready     (o_pb_ready),
    .o_vram_request (o_vram_request),
    .o_vram_rw      (o_vram_rw),
    .o_vram_address (o_vram_address),
    .o_vram_wdata   (o_vram_wdata),
    .i_vram_rdata   (vram_rdata),
    .i_vram_ready   (vram_ready),
    .o_owner        (o_owner),
    .o_busy         (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pa_req = 1'b0; pa_rw = 1'b0; pa_addr = '0; pa_wdata = '0;
    pb_req = 1'b0; pb_rw = 1'b0; pb_addr = '0; pb_wdata = '0;
    vram_ready = 1'b0; vram_rdata = '0;
  endtask

  // ---------------- directed single-port vectors ----------------
  typedef struct {
    logic        sel_b;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;        // memory wait cycles before i_vram_ready
    logic [31:0] rdata;
    int          exp_cycles; // edges from request sample to port ready
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.sel_b) begin
      pb_req = 1'b1; pb_rw = v.rw; pb_addr = v.addr; pb_wdata = v.wdata;
    end else begin
      pa_req = 1'b1; pa_rw = v.rw; pa_addr = v.addr; pa_wdata = v.wdata;
    end
    tick();
    cyc = 1;
    chkb({tag, "_vram_request"}, o_vram_request, 1'b1);
    chk({tag, "_vram_address"}, o_vram_address, v.addr);
    chkb({tag, "_vram_rw"}, o_vram_rw, v.rw);
    chk({tag, "_vram_wdata"}, o_vram_wdata, v.wdata);
    chkb({tag, "_owner"}, o_owner, v.sel_b);
    chkb({tag, "_busy_grant"}, o_busy, 1'b1);
    for (int k = 0; k < v.lat; k++) begin
      vram_rdata = $urandom;
      tick();
      cyc++;
      chkb({tag, "_wait_request"}, o_vram_request, 1'b1);
      chk({tag, "_wait_address"}, o_vram_address, v.addr);
      chk({tag, "_wait_wdata"}, o_vram_wdata, v.wdata);
      chkb({tag, "_wait_rw"}, o_vram_rw, v.rw);
      chkb({tag, "_wait_no_ready"}, o_pa_ready | o_pb_ready, 1'b0);
    end
    vram_ready = 1'b1;
    vram_rdata = v.rdata;
    tick();
    cyc++;
    vram_ready = 1'b0;
    vram_rdata = $urandom;
    chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_cycles));
    if (v.sel_b) exp_pb_rdata = v.rdata;
    else         exp_pa_rdata = v.rdata;
    chkb({tag, "_pa_ready"}, o_pa_ready, ~v.sel_b);
    chkb({tag, "_pb_ready"}, o_pb_ready, v.sel_b);
    chk({tag, "_pa_rdata"}, o_pa_rdata, exp_pa_rdata);
    chk({tag, "_pb_rdata"}, o_pb_rdata, exp_pb_rdata);
    chkb({tag, "_request_cleared"}, o_vram_request, 1'b0);
    chkb({tag, "_busy_done"}, o_busy, 1'b1);
    pa_req = 1'b0;
    pb_req = 1'b0;
    tick();
    chkb({tag, "_ready_one_cycle"}, o_pa_ready | o_pb_ready, 1'b0);
    chkb({tag, "_busy_idle"}, o_busy, 1'b0);
  endtask

  // Waits (bounded) for a memory request, completes it in one cycle; returns in the ready cycle.
  task automatic serve(output logic owner, output logic [31:0] addr, output logic ok,
                       output logic [31:0] rd);
    int t;
    t = 0;
    while (!o_vram_request && t < 20) begin
      tick();
      t++;
    end
    ok    = o_vram_request;
    owner = o_owner;
    addr  = o_vram_address;
    rd    = $urandom;
    vram_ready = 1'b1;
    vram_rdata = rd;
    tick();
    vram_ready = 1'b0;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_inflight;   // memory transaction outstanding
  logic        m_skip;       // arbiter ignores requests for one edge after completion
  int          m_streak;     // consecutive B wins while A was waiting
  logic        m_owner, m_rw, m_pa_rdy, m_pb_rdy;
  logic [31:0] m_addr, m_wdata, m_pa_rdata, m_pb_rdata;

  task automatic model_reset();
    m_inflight = 1'b0; m_skip = 1'b0; m_streak = 0;
    m_owner = 1'b0; m_rw = 1'b0; m_addr = '0; m_wdata = '0;
    m_pa_rdy = 1'b0; m_pb_rdy = 1'b0; m_pa_rdata = '0; m_pb_rdata = '0;
  endtask

  // Advances the model across one clock edge using the inputs that edge sampled.
  task automatic model_step();
    logic take_b;
    m_pa_rdy = 1'b0;
    m_pb_rdy = 1'b0;
    if (m_inflight) begin
      if (vram_ready) begin
        m_inflight = 1'b0;
        m_skip     = 1'b1;
        if (m_owner) begin m_pb_rdy = 1'b1; m_pb_rdata = vram_rdata; end
        else         begin m_pa_rdy = 1'b1; m_pa_rdata = vram_rdata; end
      end
    end else if (m_skip) begin
      m_skip = 1'b0;
    end else if (pa_req || pb_req) begin
      take_b     = pb_req && !(pa_req && m_streak >= int'(MAXB));
      m_inflight = 1'b1;
      m_owner    = take_b;
      m_rw       = take_b ? pb_rw    : pa_rw;
      m_addr     = take_b ? pb_addr  : pa_addr;
      m_wdata    = take_b ? pb_wdata : pa_wdata;
      if (take_b && pa_req) m_streak = (m_streak < int'(MAXB)) ? m_streak + 1 : int'(MAXB);
      else                  m_streak = 0;
    end
  endtask

  task automatic model_compare();
    chkb("rnd_vram_request", o_vram_request, m_inflight);
    chk("rnd_vram_address", o_vram_address, m_addr);
    chkb("rnd_vram_rw", o_vram_rw, m_rw);
    chk("rnd_vram_wdata", o_vram_wdata, m_wdata);
    chkb("rnd_owner", o_owner, m_owner);
    chkb("rnd_busy", o_busy, m_inflight | m_pa_rdy | m_pb_rdy);
    chkb("rnd_pa_ready", o_pa_ready, m_pa_rdy);
    chkb("rnd_pb_ready", o_pb_ready, m_pb_rdy);
    chk("rnd_pa_rdata", o_pa_rdata, m_pa_rdata);
    chk("rnd_pb_rdata", o_pb_rdata, m_pb_rdata);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        own, ok;
    logic [31:0] adr, rd, nb;
    logic        exp_own [10];
    logic        mem_busy;
    int          mem_wait;

    n_checks = 0;
    n_errors = 0;
    exp_pa_rdata = '0;
    exp_pb_rdata = '0;

    vecs[0] = '{sel_b: 1'b0, rw: 1'b0, addr: 32'h0000_0100, wdata: 32'h0,
                lat: 0, rdata: 32'hDEAD_BEEF, exp_cycles: 2};
    vecs[1] = '{sel_b: 1'b1, rw: 1'b0, addr: 32'h0000_2000, wdata: 32'h0,
                lat: 1, rdata: 32'h1234_5678, exp_cycles: 3};
    vecs[2] = '{sel_b: 1'b0, rw: 1'b1, addr: 32'h0000_0010, wdata: 32'h0000_0055,
                lat: 5, rdata: 32'h0BAD_F00D, exp_cycles: 7};
    vecs[3] = '{sel_b: 1'b1, rw: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'hA5A5_A5A5,
                lat: 2, rdata: 32'hCAFE_F00D, exp_cycles: 4};

    // Reset values, with both requests and memory ready held high during reset
    idle_inputs();
    rst = 1'b1;
    pa_req = 1'b1; pa_addr = 32'h44; pb_req = 1'b1; pb_addr = 32'h88;
    vram_ready = 1'b1; vram_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chkb("reset_vram_request", o_vram_request, 1'b0);
    chk("reset_vram_address", o_vram_address, 32'h0);
    chk("reset_vram_wdata", o_vram_wdata, 32'h0);
    chkb("reset_vram_rw", o_vram_rw, 1'b0);
    chkb("reset_owner", o_owner, 1'b0);
    chkb("reset_busy", o_busy, 1'b0);
    chkb("reset_pa_ready", o_pa_ready, 1'b0);
    chkb("reset_pb_ready", o_pb_ready, 1'b0);
    chk("reset_pa_rdata", o_pa_rdata, 32'h0);
    chk("reset_pb_rdata", o_pb_rdata, 32'h0);
    idle_inputs();
    rst = 1'b0;
    tick();

    // Table-driven single-port transactions
    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Both masters raise in the same cycle: B first, then A
    pa_req = 1'b1; pa_rw = 1'b1; pa_addr = 32'h10;   pa_wdata = 32'h55;
    pb_req = 1'b1; pb_rw = 1'b0; pb_addr = 32'h2000; pb_wdata = 32'h77;
    serve(own, adr, ok, rd);
    chkb("simul_first_owner", own, 1'b1);
    chk("simul_first_addr", adr, 32'h2000);
    chkb("simul_first_pb_ready", o_pb_ready, 1'b1);
    chkb("simul_first_pa_ready", o_pa_ready, 1'b0);
    chk("simul_first_pb_rdata", o_pb_rdata, rd);
    exp_pb_rdata = rd;
    pb_req = 1'b0;
    tick();
    chkb("simul_idle_gap", o_vram_request, 1'b0);
    tick();
    chkb("simul_second_request", o_vram_request, 1'b1);
    chkb("simul_second_owner", o_owner, 1'b0);
    chkb("simul_second_rw", o_vram_rw, 1'b1);
    chk("simul_second_addr", o_vram_address, 32'h10);
    chk("simul_second_wdata", o_vram_wdata, 32'h55);
    serve(own, adr, ok, rd);
    chkb("simul_second_pa_ready", o_pa_ready, 1'b1);
    chk("simul_second_pb_rdata_held", o_pb_rdata, exp_pb_rdata);
    exp_pa_rdata = rd;
    pa_req = 1'b0;
    tick();

    // Starvation guard: both held continuously
    exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pb_req = 1'b1; pb_rw = 1'b0; pb_addr = 32'h3000; pb_wdata = 32'h0;
    pa_req = 1'b1; pa_rw = 1'b1; pa_addr = 32'h80;   pa_wdata = 32'h11;
    nb = '0;
    for (int g = 0; g < 10; g++) begin
      serve(own, adr, ok, rd);
      chkb($sformatf("starve_grant_seen%0d", g), ok, 1'b1);
      chkb($sformatf("starve_owner%0d", g), own, exp_own[g]);
      if (own) begin
        chk($sformatf("starve_b_addr%0d", g), adr, 32'h3000 + (nb << 2));
        chkb($sformatf("starve_pb_ready%0d", g), o_pb_ready, 1'b1);
        chk($sformatf("starve_pb_rdata%0d", g), o_pb_rdata, rd);
        exp_pb_rdata = rd;
        nb = nb + 32'd1;
        pb_addr = pb_addr + 32'd4;
      end else begin
        chk($sformatf("starve_a_addr%0d", g), adr, 32'h80);
        chkb($sformatf("starve_pa_ready%0d", g), o_pa_ready, 1'b1);
        chk($sformatf("starve_pa_rdata%0d", g), o_pa_rdata, rd);
        exp_pa_rdata = rd;
        pa_wdata = pa_wdata + 32'd1;
      end
    end
    pa_req = 1'b0;
    pb_req = 1'b0;
    tick();

    // Stray memory ready while idle
    vram_ready = 1'b1;
    vram_rdata = 32'h1357_9BDF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chkb("stray_request", o_vram_request, 1'b0);
      chkb("stray_busy", o_busy, 1'b0);
      chkb("stray_ready", o_pa_ready | o_pb_ready, 1'b0);
      chk("stray_pa_rdata", o_pa_rdata, exp_pa_rdata);
      chk("stray_pb_rdata", o_pb_rdata, exp_pb_rdata);
    end
    vram_ready = 1'b0;
    tick();

    // Reset while a transaction is granted
    pa_req = 1'b1; pa_rw = 1'b0; pa_addr = 32'h200;
    tick();
    chkb("rstmid_granted", o_vram_request, 1'b1);
    rst = 1'b1;
    #1;
    chkb("rstmid_async_drop", o_vram_request, 1'b0);
    chkb("rstmid_busy", o_busy, 1'b0);
    vram_ready = 1'b1;
    pa_req = 1'b0;
    tick();
    chkb("rstmid_no_ready_in_reset", o_pa_ready | o_pb_ready, 1'b0);
    rst = 1'b0;
    exp_pa_rdata = '0;
    exp_pb_rdata = '0;
    tick();
    chkb("rstmid_no_ready_after", o_pa_ready | o_pb_ready, 1'b0);
    chkb("rstmid_idle", o_vram_request, 1'b0);
    vram_ready = 1'b0;
    run_vec(vecs[1], 9);

    // Random masters and memory against the reference model
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    mem_busy = 1'b0;
    mem_wait = 0;
    for (int c = 0; c < 2500; c++) begin
      tick();
      model_step();
      model_compare();
      if (o_pa_ready) pa_req = 1'b0;
      if (!pa_req && $urandom_range(0, 3) == 0) begin
        pa_req = 1'b1; pa_rw = 1'($urandom); pa_addr = $urandom; pa_wdata = $urandom;
      end
      if (o_pb_ready) pb_req = 1'b0;
      if (!pb_req && $urandom_range(0, 3) != 0) begin
        pb_req = 1'b1; pb_rw = 1'($urandom); pb_addr = $urandom; pb_wdata = $urandom;
      end
      vram_rdata = $urandom;
      if (o_vram_request) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = int'($urandom_range(0, 3));
        end
        if (mem_wait == 0) begin
          vram_ready = 1'b1;
          mem_busy   = 1'b0;
        end else begin
          vram_ready = 1'b0;
          mem_wait--;
        end
      end else begin
        mem_busy   = 1'b0;
        vram_ready = ($urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
